// File: rtl/tdpram_rd_stream_if.sv
// tdpram_rd_stream_if: request stream, RAM read port and return stream of the read sequencer (rd_addr under TDPRAM_RD_ADDR_ECHO_EN)
interface tdpram_rd_stream_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16,
   parameter int SKID_DEPTH = 4
);
   localparam int OW = $clog2(SKID_DEPTH + 1);
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_valid;
   logic                  req_ready;
   logic                  ram_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [OW-1:0]         occ;
`ifdef TDPRAM_RD_ADDR_ECHO_EN
   logic [ADDR_WIDTH-1:0] rd_addr;
`endif
   modport master (
      input  req_addr, req_valid, ram_data, rd_ready,
`ifdef TDPRAM_RD_ADDR_ECHO_EN
      output rd_addr,
`endif
      output req_ready, ram_en, ram_addr, rd_data, rd_valid, occ
   );
   modport slave (
      output req_addr, req_valid, ram_data, rd_ready,
`ifdef TDPRAM_RD_ADDR_ECHO_EN
      input  rd_addr,
`endif
      input  req_ready, ram_en, ram_addr, rd_data, rd_valid, occ
   );
endinterface

// File: rtl/tdpram_rd_stream_ctrl.sv
// tdpram_rd_stream_ctrl: RAM read sequencer with latency-matched capture into an FWFT skid FIFO; TDPRAM_RD_ADDR_ECHO_EN adds rd_addr
module tdpram_rd_stream_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16,
   parameter bit OUTPUT_REG = 1'b0,
   parameter int SKID_DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   tdpram_rd_stream_if.master bus
);
   localparam int LAT = OUTPUT_REG ? 2 : 1;
   localparam int OW  = $clog2(SKID_DEPTH + 1);
   localparam int PW  = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;
   if (SKID_DEPTH < LAT) begin : g_depth_check
      $error("SKID_DEPTH must be at least the RAM read latency");
   end
   logic [LAT-1:0]        pipe_v;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [OW-1:0]         cnt, inflight, total;
   logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
   logic                  accept, push, pop;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(SKID_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) inflight = inflight + OW'(pipe_v[i]);
   end
   // Credits count every word not yet popped, so the FIFO can never overflow.
   assign total         = inflight + cnt;
   assign bus.req_ready = total < OW'(SKID_DEPTH);
   assign accept        = bus.req_valid & bus.req_ready;
   assign bus.ram_en    = accept;
   assign bus.ram_addr  = bus.req_addr;
   assign push          = pipe_v[LAT-1];
   assign bus.rd_valid  = cnt != '0;
   assign pop           = bus.rd_valid & bus.rd_ready;
   assign bus.rd_data   = bus.rd_valid ? mem_d[rd_ptr] : '0;
   assign bus.occ       = total;
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         assert (!(push && cnt == OW'(SKID_DEPTH)));
         pipe_v[0] <= accept;
         for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop) rd_ptr <= nxt(rd_ptr);
         cnt <= cnt + OW'(push) - OW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_d[wr_ptr] <= bus.ram_data;
   end
`ifdef TDPRAM_RD_ADDR_ECHO_EN
   logic [ADDR_WIDTH-1:0] pipe_a [LAT];
   logic [ADDR_WIDTH-1:0] mem_a  [SKID_DEPTH];
   always_ff @(posedge clk) begin
      pipe_a[0] <= bus.req_addr;
      for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
      if (push) mem_a[wr_ptr] <= pipe_a[LAT-1];
   end
   assign bus.rd_addr = bus.rd_valid ? mem_a[rd_ptr] : '0;
`endif
endmodule

// File: tb/tb_tdpram_rd_stream_ctrl.sv
// tb_tdpram_rd_stream_ctrl: three sequencer instances (LAT1/depth4, LAT2/depth4, LAT1/depth3) checked against a request-queue model
module tb_tdpram_rd_stream_ctrl;
   localparam int AW = 9;
   localparam int DW = 16;
   localparam int NI = 3;
   localparam int QN = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic          rv [NI], rr [NI], rdy [NI], en [NI], v [NI];
   logic [AW-1:0] ra [NI], rama [NI], ea [NI];
   logic [DW-1:0] rd [NI];
   logic [2:0]    occ [NI];
   logic [DW-1:0] s1;
   int qa [NI][QN];
   int qt [NI][QN];
   int hd [NI], tl [NI], fa [NI], fv [NI];
   logic [DW-1:0] fd [NI];
   int cyc = 0, checks = 0, passed = 0;
   function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
      return 16'hC000 | {7'b0, a};
   endfunction
   function automatic int lat_of(input int i);
      return i == 1 ? 2 : 1;
   endfunction
   function automatic int dep_of(input int i);
      return i == 2 ? 3 : 4;
   endfunction
   tdpram_rd_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKID_DEPTH(4)) b0 ();
   tdpram_rd_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKID_DEPTH(4)) b1 ();
   tdpram_rd_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SKID_DEPTH(3)) b2 ();
   tdpram_rd_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b0), .SKID_DEPTH(4))
      d0 (.clk(clk), .rst(rst), .bus(b0.master));
   tdpram_rd_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b1), .SKID_DEPTH(4))
      d1 (.clk(clk), .rst(rst), .bus(b1.master));
   tdpram_rd_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b0), .SKID_DEPTH(3))
      d2 (.clk(clk), .rst(rst), .bus(b2.master));
   assign b0.req_valid = rv[0];
   assign b0.req_addr  = ra[0];
   assign b0.rd_ready  = rr[0];
   assign b1.req_valid = rv[1];
   assign b1.req_addr  = ra[1];
   assign b1.rd_ready  = rr[1];
   assign b2.req_valid = rv[2];
   assign b2.req_addr  = ra[2];
   assign b2.rd_ready  = rr[2];
   assign rdy[0] = b0.req_ready;
   assign rdy[1] = b1.req_ready;
   assign rdy[2] = b2.req_ready;
   assign en[0] = b0.ram_en;
   assign en[1] = b1.ram_en;
   assign en[2] = b2.ram_en;
   assign rama[0] = b0.ram_addr;
   assign rama[1] = b1.ram_addr;
   assign rama[2] = b2.ram_addr;
   assign v[0] = b0.rd_valid;
   assign v[1] = b1.rd_valid;
   assign v[2] = b2.rd_valid;
   assign rd[0] = b0.rd_data;
   assign rd[1] = b1.rd_data;
   assign rd[2] = b2.rd_data;
   assign occ[0] = b0.occ;
   assign occ[1] = b1.occ;
   assign occ[2] = {1'b0, b2.occ};
`ifdef TDPRAM_RD_ADDR_ECHO_EN
   assign ea[0] = b0.rd_addr;
   assign ea[1] = b1.rd_addr;
   assign ea[2] = b2.rd_addr;
`else
   assign ea[0] = '0;
   assign ea[1] = '0;
   assign ea[2] = '0;
`endif
   // RAM models: junk when the port is not enabled exposes a mis-timed capture.
   always @(posedge clk) begin
      b0.ram_data <= b0.ram_en ? f(b0.ram_addr) : 16'hDEAD;
      b2.ram_data <= b2.ram_en ? f(b2.ram_addr) : 16'hDEAD;
      s1          <= b1.ram_en ? f(b1.ram_addr) : 16'hDEAD;
      b1.ram_data <= s1;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask
   task automatic fail_now(input string name, input int info);
      checks++;
      $display("FAIL %s at cycle %0d: bound expired (%0d outstanding)", name, cyc, info);
   endtask
   // Model: a word is visible LAT+1 cycles after its accept once it reaches the queue head.
   initial begin : mon
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            int n;
            bit ev, acc;
            logic [AW-1:0] ha;
            n   = tl[i] - hd[i];
            ha  = AW'(qa[i][hd[i] % QN]);
            ev  = n > 0 && cyc >= qt[i][hd[i] % QN] + lat_of(i) + 1;
            acc = !rst && rv[i] && n < dep_of(i);
            if (!rst) begin
               chk($sformatf("rd_valid[%0d]", i), 32'(v[i]), 32'(ev));
               chk($sformatf("req_ready[%0d]", i), 32'(rdy[i]), 32'(n < dep_of(i)));
               chk($sformatf("occ[%0d]", i), 32'(occ[i]), 32'(n));
               chk($sformatf("ram_en[%0d]", i), 32'(en[i]), 32'(acc));
               if (acc) chk($sformatf("ram_addr[%0d]", i), 32'(rama[i]), 32'(ra[i]));
               if (ev) chk($sformatf("rd_data[%0d]", i), 32'(rd[i]), 32'(f(ha)));
               else chk($sformatf("rd_data_idle[%0d]", i), 32'(rd[i]), 32'(0));
`ifdef TDPRAM_RD_ADDR_ECHO_EN
               if (ev) chk($sformatf("rd_addr[%0d]", i), 32'(ea[i]), 32'(ha));
`endif
               if (v[i] && fv[i] < 0) begin
                  fv[i] = cyc;
                  fd[i] = rd[i];
               end
            end
            if (acc && fa[i] < 0) fa[i] = cyc;
            if (rst) begin
               hd[i] = 0;
               tl[i] = 0;
            end else begin
               if (ev && rr[i]) hd[i]++;
               if (acc) begin
                  qa[i][tl[i] % QN] = int'(ra[i]);
                  qt[i][tl[i] % QN] = cyc;
                  tl[i]++;
               end
            end
         end
         cyc++;
      end
   end
   // rmode: 0 consumer ready, 1 consumer stalled, 2 ready toggling every cycle
   task automatic stream(input int i, input int n, input int base, input bit rnd, input int rmode);
      bit acc, tog;
      int guard;
      tog = 1'b1;
      guard = 0;
      for (int k = 0; k < n; k++) begin
         rv[i] = 1'b1;
         ra[i] = rnd ? AW'($urandom) : AW'(base + k);
         do begin
            rr[i] = rmode == 0 ? 1'b1 : rmode == 1 ? 1'b0 : tog;
            tog = !tog;
            @(negedge clk);
            acc = rdy[i];
            @(posedge clk);
            #1;
            guard++;
         end while (!acc && guard < 400);
         if (!acc) begin
            fail_now($sformatf("accept_timeout[%0d]", i), n - k);
            break;
         end
      end
      rv[i] = 1'b0;
   endtask
   task automatic drain(input int i);
      int g;
      g = 0;
      rv[i] = 1'b0;
      rr[i] = 1'b1;
      while (tl[i] != hd[i] && g < 60) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (tl[i] != hd[i]) fail_now($sformatf("drain_timeout[%0d]", i), tl[i] - hd[i]);
   endtask
   initial begin
      for (int i = 0; i < NI; i++) begin
         rv[i] = 1'b0;
         rr[i] = 1'b1;
         ra[i] = '0;
         hd[i] = 0;
         tl[i] = 0;
         fa[i] = -1;
         fv[i] = -1;
         fd[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      stream(0, 16, 0, 1'b0, 0);
      drain(0);
      chk("first_latency_lat1", 32'(fv[0] - fa[0]), 32'd2);
      chk("first_word_lat1", 32'(fd[0]), 32'hC000);
      stream(1, 16, 0, 1'b0, 0);
      drain(1);
      chk("first_latency_lat2", 32'(fv[1] - fa[1]), 32'd3);
      chk("first_word_lat2", 32'(fd[1]), 32'hC000);
      stream(0, 4, 32, 1'b0, 1);
      rv[0] = 1'b1;
      ra[0] = AW'(36);
      rr[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stall_occ", 32'(occ[0]), 32'd4);
      chk("stall_ready", 32'(rdy[0]), 32'd0);
      chk("stall_valid", 32'(v[0]), 32'd1);
      chk("stall_head", 32'(rd[0]), 32'hC020);
      @(posedge clk);
      #1;
      stream(0, 2, 36, 1'b0, 0);
      drain(0);
      stream(2, 10, 100, 1'b0, 2);
      drain(2);
      stream(1, 4, 64, 1'b0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_valid", 32'(v[1]), 32'd0);
      chk("post_reset_occ", 32'(occ[1]), 32'd0);
      chk("post_reset_ready", 32'(rdy[1]), 32'd1);
      rr[1] = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      stream(0, 12, 0, 1'b1, 2);
      drain(0);
      stream(2, 8, 0, 1'b1, 2);
      drain(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
